// File: rtl/hamming_enc_arbiter.sv
// Purpose: two-requester round-robin arbiter feeding a Hamming(11,7) encoder into a one-entry output register.
// Latency: 1 cycle from an accepted request to out_valid carrying its codeword.
// Backpressure: out_ready low holds the output word and drops both reqN_ready; a draining slot is refilled in the same cycle.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   reqN_valid/reqN_data/reqN_ready - requester N offer (7-bit data word) and acceptance
//   out_valid/out_code/out_src    - held codeword and the requester that supplied it
//   out_ready                     - downstream accepts the held word
//   cnt0, cnt1                    - wrapping counts of words accepted per requester
module hamming_enc_arbiter #(
    parameter int PRIO_INIT = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [6:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [6:0]       req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [10:0]      out_code,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // The pointer records the last winner, so resetting it to the opposite
    // of PRIO_INIT makes PRIO_INIT win the first contention.
    localparam logic PTR_RST = (PRIO_INIT == 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             out_valid_q, out_valid_d;
    logic [10:0]      out_code_q,  out_code_d;
    logic             out_src_q,   out_src_d;
    logic             last_q,      last_d;
    logic [CNT_W-1:0] cnt0_q,      cnt0_d;
    logic [CNT_W-1:0] cnt1_q,      cnt1_d;

    logic       slot_free;
    logic       gnt_vld;
    logic       gnt_sel;
    logic [6:0] gnt_data;

    function automatic logic [10:0] hamming_encode(input logic [6:0] d);
        logic p1, p2, p3, p4;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p3 = d[1] ^ d[2] ^ d[3];
        p4 = d[4] ^ d[5] ^ d[6];
        return {d[6], d[5], d[4], p4, d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        // Contention goes to the requester opposite the last winner; otherwise
        // the lone valid requester (req1_valid alone selects 1).
        if (req0_valid && req1_valid) begin
            gnt_sel = ~last_q;
        end else begin
            gnt_sel = req1_valid;
        end
        gnt_vld    = slot_free && (req0_valid || req1_valid) && !rst;
        req0_ready = gnt_vld && !gnt_sel;
        req1_ready = gnt_vld && gnt_sel;
        gnt_data   = gnt_sel ? req1_data : req0_data;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (gnt_vld) begin
            // Covers the drain-and-refill case too: no bubble between words.
            out_valid_d = 1'b1;
            out_code_d  = hamming_encode(gnt_data);
            out_src_d   = gnt_sel;
            last_d      = gnt_sel;
            if (gnt_sel) begin
                cnt1_d = cnt1_q + CNT_ONE;
            end else begin
                cnt0_d = cnt0_q + CNT_ONE;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_src_q   <= 1'b0;
            last_q      <= PTR_RST;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_src   = out_src_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Purpose: self-checking bench for hamming_enc_arbiter (vector table, corner sequences, random scoreboard).
// Latency: expects each accepted word on the outputs one clock after acceptance.
// Backpressure: exercises held words under out_ready low and same-cycle drain/refill.
module tb_hamming_enc_arbiter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [6:0]    req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          out_valid, out_src, out_ready;
    logic [10:0]   out_code;
    logic [CW-1:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    hamming_enc_arbiter #(.PRIO_INIT(0), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  d;
        logic [10:0] code;
    } vec_t;

    vec_t vecs[5];

    // Reference encoder: classic Hamming layout, codeword bit i is position i+1,
    // data fills non-power-of-two positions, parity at 2^b covers positions with bit b set.
    function automatic logic [10:0] ref_code(input logic [6:0] d);
        logic [11:1] pos;
        logic        x;
        int          k;
        pos = '0;
        k   = 0;
        for (int p = 1; p <= 11; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int p = 1; p <= 11; p++) begin
                if ((((p >> b) & 1) != 0) && (p != (1 << b))) x = x ^ pos[p];
            end
            pos[1 << b] = x;
        end
        return pos;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [6:0]  da, db;
    logic [11:0] pend[$];
    logic        m_pref, g_vld, g_src, sf;
    int          m_cnt0, m_cnt1;

    initial begin
        vecs[0] = '{7'h00, 11'h000};
        vecs[1] = '{7'h7F, 11'h7FF};
        vecs[2] = '{7'h01, 11'h007};
        vecs[3] = '{7'h40, 11'h483};
        vecs[4] = '{7'h55, 11'h52F};

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_code", 32'(out_code), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        step();
        chk("rst_no_xfer", 32'(out_valid), 0);
        rst = 1'b0;
        req1_valid = 1'b0;

        // Vector table: requester 0 alone, downstream always ready.
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_data  = vecs[i].d;
            #1;
            chk("vec_ready0", 32'(req0_ready), 1);
            step();
            chk("vec_out_valid", 32'(out_valid), 1);
            chk("vec_out_code", 32'(out_code), 32'(vecs[i].code));
            chk("vec_out_src", 32'(out_src), 0);
        end
        req0_valid = 1'b0;
        step();
        chk("drain_out_valid", 32'(out_valid), 0);
        step();
        chk("idle_ready_out_valid", 32'(out_valid), 0);
        chk("idle_cnt0", 32'(cnt0), 5);

        // Continuous contention alternates starting with requester 0.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            da = 7'($urandom);
            db = 7'($urandom);
            req0_data = da;
            req1_data = db;
            #1;
            chk("rr_ready0", 32'(req0_ready), 32'((i % 2) == 0));
            chk("rr_ready1", 32'(req1_ready), 32'((i % 2) == 1));
            step();
            chk("rr_out_src", 32'(out_src), 32'(i % 2));
            chk("rr_out_code", 32'(out_code), 32'(ref_code((i % 2) == 1 ? db : da)));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_cnt0", 32'(cnt0), 4);
        chk("rr_cnt1", 32'(cnt1), 4);

        // Backpressure: held word stable, no grants, then drain and refill same cycle.
        da = 7'h2A; db = 7'h13;
        req0_valid = 1'b1; req0_data = da; out_ready = 1'b1;
        step();
        req0_valid = 1'b0; out_ready = 1'b0;
        req1_valid = 1'b1; req1_data = db;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready0", 32'(req0_ready), 0);
            chk("bp_ready1", 32'(req1_ready), 0);
            step();
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_code", 32'(out_code), 32'(ref_code(da)));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_refill_ready1", 32'(req1_ready), 1);
        step();
        chk("bp_refill_code", 32'(out_code), 32'(ref_code(db)));
        chk("bp_refill_src", 32'(out_src), 1);
        chk("bp_refill_valid", 32'(out_valid), 1);
        req1_valid = 1'b0;

        // Leave requester 0 as last winner and a word held, then reset mid-flight.
        req0_valid = 1'b1; req0_data = 7'h66;
        step();
        req0_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("midrst_ready0", 32'(req0_ready), 0);
        chk("midrst_ready1", 32'(req1_ready), 0);
        step();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_code", 32'(out_code), 0);
        chk("midrst_cnt0", 32'(cnt0), 0);
        chk("midrst_cnt1", 32'(cnt1), 0);
        out_ready = 1'b1;
        #1;
        chk("midrst_prio_ready0", 32'(req0_ready), 1);
        chk("midrst_prio_ready1", 32'(req1_ready), 0);
        step();
        chk("midrst_prio_src", 32'(out_src), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Counter wrap: 17 accepts from requester 1 on a 4-bit counter.
        do_reset();
        req1_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            req1_data = 7'(i);
            step();
        end
        req1_valid = 1'b0;
        chk("wrap_cnt1", 32'(cnt1), 1);
        chk("wrap_cnt0", 32'(cnt0), 0);

        // Random traffic against a queue-based scoreboard.
        do_reset();
        pend.delete();
        m_pref = 1'b0;
        m_cnt0 = 0;
        m_cnt1 = 0;
        for (int c = 0; c < 600; c++) begin
            req0_valid = ($urandom % 4) != 0;
            req1_valid = ($urandom % 4) != 0;
            req0_data  = 7'($urandom);
            req1_data  = 7'($urandom);
            out_ready  = ($urandom % 3) != 0;
            #1;
            chk("rnd_cnt0", 32'(cnt0), 32'(m_cnt0));
            chk("rnd_cnt1", 32'(cnt1), 32'(m_cnt1));
            chk("rnd_out_valid", 32'(out_valid), 32'(pend.size() != 0));
            sf    = (pend.size() == 0) || out_ready;
            g_vld = sf && (req0_valid || req1_valid);
            if (req0_valid && req1_valid) g_src = m_pref;
            else                          g_src = req1_valid;
            chk("rnd_ready0", 32'(req0_ready), 32'(g_vld && !g_src));
            chk("rnd_ready1", 32'(req1_ready), 32'(g_vld && g_src));
            if (pend.size() != 0 && out_ready) begin
                chk("rnd_out_code", 32'(out_code), 32'(pend[0][10:0]));
                chk("rnd_out_src", 32'(out_src), 32'(pend[0][11]));
                void'(pend.pop_front());
            end
            if (g_vld) begin
                pend.push_back({g_src, ref_code(g_src ? req1_data : req0_data)});
                if (g_src) m_cnt1 = (m_cnt1 + 1) % 16;
                else       m_cnt0 = (m_cnt0 + 1) % 16;
                m_pref = !g_src;
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
